prism_cfg_loader: RTL and testbench

- Sequences reconfiguration of the PRISM FSM controller's 6-bit debug/config port: stages (address, data) config writes in a FIFO, then on command resets PRISM, bursts the staged words into it, and re-enables it.
- Sits between the TinyQV peripheral register decode and the PRISM debug port.
- Arbitrates that port: the host has direct pass-through when the loader is idle and is stalled while a load runs.

---
 rtl/prism_cfg_loader_if.sv | 23 ++
 rtl/prism_cfg_loader.sv | 192 +++++++++++++++++++
 tb/tb_prism_cfg_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prism_cfg_loader_if.sv
// Host-side debug bus of the PRISM config loader.
// Handshake: the host raises host_wr or host_rd together with host_addr/host_wdata
// and holds all of them stable until host_ready is seen high at a rising clk edge.
// That edge is the single cycle in which the access takes effect.
// host_rdata is valid in that same cycle.
interface prism_cfg_loader_if;
   logic [5:0]  host_addr;
   logic [31:0] host_wdata;
   logic        host_wr;
   logic        host_rd;
   logic [31:0] host_rdata;
   logic        host_ready;

   modport master (
      output host_addr, host_wdata, host_wr, host_rd,
      input  host_rdata, host_ready
   );

   modport slave (
      input  host_addr, host_wdata, host_wr, host_rd,
      output host_rdata, host_ready
   );
endinterface

// File: rtl/prism_cfg_loader.sv
// PRISM config loader: stages (addr, data) writes in a FIFO and, on go, holds PRISM in
// reset, bursts the staged writes into its debug port, releases reset, and re-enables it.
// While idle, the host reaches the PRISM debug port directly.
// While a load runs, the host is stalled.
module prism_cfg_loader #(
   parameter int DEPTH         = 8,
   parameter int HALT_CYCLES   = 2,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   prism_cfg_loader_if.slave        host,
   input  logic                     stg_push,
   input  logic [5:0]               stg_addr,
   input  logic [31:0]              stg_data,
   input  logic                     go,
   input  logic                     abort,
   output logic [5:0]               prism_addr,
   output logic [31:0]              prism_wdata,
   output logic                     prism_wr,
   input  logic [31:0]              prism_rdata,
   output logic                     prism_reset,
   output logic                     prism_enable,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   stg_count,
   output logic                     stg_full,
   output logic                     overflow,
   output logic                     done_irq,
   output logic [2:0]               dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE     = AW'(1);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
   localparam logic [3:0]    HALT_LOAD   = 4'(HALT_CYCLES - 1);
   localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HALT    = 3'd1,
      S_LOAD    = 3'd2,
      S_RELEASE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic [5:0]      mem_addr [DEPTH];
   logic [31:0]     mem_data [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            prism_reset_q;
   logic            prism_enable_q;
   logic            overflow_q;
   logic            done_q;

   logic            idle;
   logic            go_ok;
   logic            fifo_empty;
   logic            fifo_full;
   logic            push_ok;
   logic            push_drop;
   logic            pop;
   logic            pass_ok;

   assign idle       = (state == S_IDLE);
   // go is only honoured from IDLE, and abort always beats it.
   assign go_ok      = idle & go & ~abort;
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == DEPTH_C);
   // Staging is only open while idle; anything else is dropped and flagged.
   assign push_ok    = stg_push & idle & ~fifo_full & ~abort & ~rst;
   assign push_drop  = stg_push & (~idle | fifo_full);
   // One write per LOAD cycle straight from the FIFO head.
   assign pop        = (state == S_LOAD) & ~fifo_empty & ~abort & ~rst;
   // Host pass-through is live only in IDLE and yields to a same-cycle go.
   assign pass_ok    = idle & ~go_ok & ~rst;

   assign prism_addr      = (state == S_LOAD) ? mem_addr[rd_ptr] : host.host_addr;
   assign prism_wdata     = (state == S_LOAD) ? mem_data[rd_ptr] : host.host_wdata;
   assign prism_wr        = pop | (pass_ok & host.host_wr);
   assign host.host_ready = pass_ok & (host.host_wr | host.host_rd);
   assign host.host_rdata = prism_rdata;

   assign prism_reset  = prism_reset_q;
   assign prism_enable = prism_enable_q;
   assign busy         = ~idle;
   assign stg_count    = count;
   assign stg_full     = fifo_full;
   assign overflow     = overflow_q;
   assign done_irq     = done_q;
   assign dbg_state    = state;

   // Staging storage; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_addr[wr_ptr] <= stg_addr;
         mem_data[wr_ptr] <= stg_data;
      end
   end

   // FIFO pointers and occupancy; reset and abort both flush the FIFO.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count + CNT_ONE;
         end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            count  <= count - CNT_ONE;
         end
      end
   end

   // Load sequencer: IDLE -> HALT -> LOAD -> RELEASE -> DONE -> IDLE, with registered control outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         cnt            <= '0;
         prism_reset_q  <= 1'b0;
         prism_enable_q <= 1'b0;
         overflow_q     <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         if (go_ok) begin
            overflow_q <= 1'b0;
         end
         if (push_drop) begin
            overflow_q <= 1'b1;
         end
         if (abort) begin
            done_q <= 1'b0;
            if (!idle) begin
               state          <= S_IDLE;
               prism_reset_q  <= 1'b0;
               prism_enable_q <= 1'b0;
            end
         end else begin
            case (state)
               S_IDLE: begin
                  if (go_ok) begin
                     state          <= S_HALT;
                     cnt            <= HALT_LOAD;
                     prism_reset_q  <= 1'b1;
                     prism_enable_q <= 1'b0;
                     done_q         <= 1'b0;
                  end
               end
               S_HALT: begin
                  if (cnt == 4'd0) begin
                     state <= S_LOAD;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
               S_LOAD: begin
                  // The cycle that finds the FIFO empty writes nothing and leaves.
                  if (fifo_empty) begin
                     state         <= S_RELEASE;
                     cnt           <= SETTLE_LOAD;
                     prism_reset_q <= 1'b0;
                  end
               end
               S_RELEASE: begin
                  // Stays SETTLE_CYCLES cycles, but always at least one.
                  if (cnt <= 4'd1) begin
                     state <= S_DONE;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
               S_DONE: begin
                  prism_enable_q <= 1'b1;
                  done_q         <= 1'b1;
                  state          <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prism_cfg_loader.sv
// Self-checking bench for prism_cfg_loader: pass-through vector table plus load sequences.
module tb_prism_cfg_loader;

   localparam int DEPTH  = 8;
   localparam int HALT   = 2;
   localparam int SETTLE = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   prism_cfg_loader_if u_if ();

   logic        stg_push;
   logic [5:0]  stg_addr;
   logic [31:0] stg_data;
   logic        go;
   logic        abort;
   logic [5:0]  prism_addr;
   logic [31:0] prism_wdata;
   logic        prism_wr;
   logic [31:0] prism_rdata;
   logic        prism_reset;
   logic        prism_enable;
   logic        busy;
   logic [3:0]  stg_count;
   logic        stg_full;
   logic        overflow;
   logic        done_irq;
   logic [2:0]  dbg_state;

   prism_cfg_loader #(
      .DEPTH(DEPTH), .HALT_CYCLES(HALT), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk(clk), .rst(rst), .host(u_if),
      .stg_push(stg_push), .stg_addr(stg_addr), .stg_data(stg_data),
      .go(go), .abort(abort),
      .prism_addr(prism_addr), .prism_wdata(prism_wdata), .prism_wr(prism_wr),
      .prism_rdata(prism_rdata), .prism_reset(prism_reset), .prism_enable(prism_enable),
      .busy(busy), .stg_count(stg_count), .stg_full(stg_full), .overflow(overflow),
      .done_irq(done_irq), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [37:0] exp_q[$];

   int ld_nwr, ld_first, ld_last, ld_en, ld_rst_hi, ld_ready_busy, ld_go_ready, host_hits;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [5:0] a, input logic [31:0] d);
      stg_push = 1'b1;
      stg_addr = a;
      stg_data = d;
      tick();
      stg_push = 1'b0;
   endtask

   // Pulses go in the current cycle (cycle 0) and watches the load until prism_enable rises.
   task automatic run_load(input string tag, input int n);
      logic [37:0] e;
      ld_nwr = 0; ld_first = -1; ld_last = -1; ld_en = -1;
      ld_rst_hi = 0; ld_ready_busy = 0; host_hits = 0;
      go = 1'b1;
      #1;
      ld_go_ready = int'(u_if.host_ready);
      if (!busy && prism_wr && prism_addr == 6'h10) host_hits++;
      for (int c = 1; c <= 100 && ld_en < 0; c++) begin
         @(posedge clk);
         #1;
         go = 1'b0;
         #1;
         if (busy && prism_wr) begin
            ld_nwr++;
            if (ld_first < 0) ld_first = c;
            ld_last = c;
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check({tag, "_wr_addr"}, prism_addr, e[37:32]);
               check({tag, "_wr_data"}, prism_wdata, e[31:0]);
            end
         end
         if (busy && u_if.host_ready) ld_ready_busy++;
         if (!busy && prism_wr && prism_addr == 6'h10 && prism_wdata == 32'hDEADBEEF) host_hits++;
         if (prism_reset) ld_rst_hi++;
         if (prism_enable) ld_en = c;
      end
      check({tag, "_enable_cycle"}, ld_en, 3 + HALT + n + SETTLE);
      check({tag, "_num_writes"}, ld_nwr, n);
      check({tag, "_reset_cycles"}, ld_rst_hi, HALT + n + 1);
      check({tag, "_go_host_ready"}, ld_go_ready, 0);
      check({tag, "_ready_while_busy"}, ld_ready_busy, 0);
      check({tag, "_sb_left"}, exp_q.size(), 0);
      if (n > 0) begin
         check({tag, "_first_wr_cycle"}, ld_first, 1 + HALT);
         check({tag, "_wr_span"}, ld_last - ld_first, n - 1);
      end
   endtask

   // ---------------- pass-through vector table ----------------
   typedef struct {
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic        wr;
      logic        rd;
      logic [31:0] rdata;
      logic [5:0]  e_addr;
      logic [31:0] e_wdata;
      logic        e_wr;
      logic        e_ready;
      logic [31:0] e_rdata;
   } pt_vec_t;

   pt_vec_t vecs[5];
   logic found;

   initial begin
      vecs[0] = '{6'h01, 32'h0000_0001, 1'b1, 1'b0, 32'hAAAA_5555, 6'h01, 32'h0000_0001, 1'b1, 1'b1, 32'hAAAA_5555};
      vecs[1] = '{6'h3F, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h1234_5678, 6'h3F, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h1234_5678};
      vecs[2] = '{6'h2A, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h0000_0000, 6'h2A, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h0000_0000};
      vecs[3] = '{6'h15, 32'hA5A5_A5A5, 1'b1, 1'b1, 32'h8765_4321, 6'h15, 32'hA5A5_A5A5, 1'b1, 1'b1, 32'h8765_4321};
      vecs[4] = '{6'h00, 32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 6'h00, 32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFF};

      rst = 1'b1;
      stg_push = 1'b0; stg_addr = '0; stg_data = '0;
      go = 1'b0; abort = 1'b0; prism_rdata = '0;
      u_if.host_addr = '0; u_if.host_wdata = '0; u_if.host_wr = 1'b0; u_if.host_rd = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // ---- reset state ----
      check("rst_busy", busy, 0);
      check("rst_prism_reset", prism_reset, 0);
      check("rst_prism_enable", prism_enable, 0);
      check("rst_prism_wr", prism_wr, 0);
      check("rst_stg_count", stg_count, 0);
      check("rst_stg_full", stg_full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_done_irq", done_irq, 0);
      check("rst_host_ready", u_if.host_ready, 0);
      tick();

      // ---- idle pass-through table ----
      foreach (vecs[i]) begin
         u_if.host_addr  = vecs[i].addr;
         u_if.host_wdata = vecs[i].wdata;
         u_if.host_wr    = vecs[i].wr;
         u_if.host_rd    = vecs[i].rd;
         prism_rdata     = vecs[i].rdata;
         #1;
         check("pt_addr", prism_addr, vecs[i].e_addr);
         check("pt_wdata", prism_wdata, vecs[i].e_wdata);
         check("pt_wr", prism_wr, vecs[i].e_wr);
         check("pt_ready", u_if.host_ready, vecs[i].e_ready);
         check("pt_rdata", u_if.host_rdata, vecs[i].e_rdata);
         tick();
      end
      u_if.host_wr = 1'b0; u_if.host_rd = 1'b0;
      tick();

      // ---- T1: three staged writes ----
      push(6'h04, 32'h1111_1111); exp_q.push_back({6'h04, 32'h1111_1111});
      push(6'h08, 32'h2222_2222); exp_q.push_back({6'h08, 32'h2222_2222});
      push(6'h0C, 32'h3333_3333); exp_q.push_back({6'h0C, 32'h3333_3333});
      #1;
      check("t1_count_staged", stg_count, 3);
      run_load("t1", 3);
      check("t1_done_irq", done_irq, 1);
      check("t1_count_after", stg_count, 0);
      tick();

      // ---- T2: overflow with DEPTH+1 pushes ----
      for (int i = 0; i < 9; i++) begin
         push(6'(i + 1), 32'hA000_0000 + 32'(i));
         if (i < 8) exp_q.push_back({6'(i + 1), 32'hA000_0000 + 32'(i)});
      end
      #1;
      check("t2_full", stg_full, 1);
      check("t2_overflow", overflow, 1);
      check("t2_count", stg_count, 8);
      run_load("t2", 8);
      check("t2_overflow_after", overflow, 0);
      check("t2_full_after", stg_full, 0);
      tick();

      // ---- T3: host write held across a load ----
      push(6'h20, 32'h0102_0304); exp_q.push_back({6'h20, 32'h0102_0304});
      push(6'h24, 32'h0506_0708); exp_q.push_back({6'h24, 32'h0506_0708});
      u_if.host_addr = 6'h10; u_if.host_wdata = 32'hDEAD_BEEF; u_if.host_wr = 1'b1;
      prism_rdata = 32'h5A5A_0000;
      run_load("t3", 2);
      check("t3_host_ready_idle", u_if.host_ready, 1);
      check("t3_pass_wr", prism_wr, 1);
      check("t3_pass_addr", prism_addr, 6'h10);
      check("t3_pass_data", prism_wdata, 32'hDEAD_BEEF);
      tick();
      u_if.host_wr = 1'b0;
      #1;
      check("t3_host_hits", host_hits, 1);
      check("t3_wr_dropped", prism_wr, 0);
      u_if.host_addr = 6'h11; u_if.host_rd = 1'b1; prism_rdata = 32'hCAFE_F00D;
      #1;
      check("t3_rd_ready", u_if.host_ready, 1);
      check("t3_rd_data", u_if.host_rdata, 32'hCAFE_F00D);
      tick();
      u_if.host_rd = 1'b0;
      tick();

      // ---- T4: abort after 1 of 4 writes ----
      for (int i = 0; i < 4; i++) begin
         push(6'(6'h30 + i), 32'hB000_0000 + 32'(i));
      end
      go = 1'b1;
      tick();
      go = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         #1;
         if (busy && prism_wr) begin
            found = 1'b1;
            check("t4_first_addr", prism_addr, 6'h30);
            check("t4_first_data", prism_wdata, 32'hB000_0000);
         end else begin
            tick();
         end
      end
      check("t4_first_seen", found, 1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      #1;
      check("t4_busy", busy, 0);
      check("t4_prism_reset", prism_reset, 0);
      check("t4_prism_enable", prism_enable, 0);
      check("t4_count", stg_count, 0);
      check("t4_done_irq", done_irq, 0);
      ld_nwr = 0;
      for (int c = 0; c < 10; c++) begin
         if (prism_wr) ld_nwr++;
         tick();
      end
      check("t4_no_more_wr", ld_nwr, 0);

      // ---- T5: go with empty FIFO ----
      run_load("t5", 0);
      check("t5_done_irq", done_irq, 1);
      tick();

      // ---- T6: reset mid-LOAD, then empty load ----
      push(6'h01, 32'h1); push(6'h02, 32'h2); push(6'h03, 32'h3);
      go = 1'b1;
      tick();
      go = 1'b0;
      tick();
      stg_push = 1'b1; stg_addr = 6'h3E; stg_data = 32'h0;
      tick();
      stg_push = 1'b0;
      #1;
      check("t6_ovf_pre", overflow, 1);
      check("t6_busy_pre", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_prism_reset", prism_reset, 0);
      check("t6_prism_enable", prism_enable, 0);
      check("t6_prism_wr", prism_wr, 0);
      check("t6_count", stg_count, 0);
      check("t6_overflow", overflow, 0);
      check("t6_done_irq", done_irq, 0);
      check("t6_host_ready", u_if.host_ready, 0);
      tick();
      run_load("t6", 0);
      check("t6_done_after", done_irq, 1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
